// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level RV32 instruction descriptions into R/I/S/B/J words behind one output register stage.
// Optional macro ENCODER_CHECK_EN enables immediate range checks, NOP substitution and the sticky error flags.
module instr_encoder #(
    parameter int          WIDTH     = 32,
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [20:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_instr,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              addr_clr,
    input  logic              err_clr,
    output logic              err_imm,
    output logic              err_kind
);
    localparam logic [WIDTH-1:0]  NOP      = WIDTH'(32'h0000_0013);
    localparam logic [ADDR_W-1:0] ADDR_RST = ADDR_W'(BASE_ADDR);

    localparam logic [2:0] KIND_R      = 3'd0;
    localparam logic [2:0] KIND_I      = 3'd1;
    localparam logic [2:0] KIND_LOAD   = 3'd2;
    localparam logic [2:0] KIND_STORE  = 3'd3;
    localparam logic [2:0] KIND_BRANCH = 3'd4;
    localparam logic [2:0] KIND_JAL    = 3'd5;
    localparam logic [2:0] KIND_JALR   = 3'd6;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              err_imm_q, err_imm_d;
    logic              err_kind_q, err_kind_d;

    logic             is_shift;
    logic [WIDTH-1:0] enc_word;
    logic             imm_bad;
    logic             kind_bad;
    logic             in_fire;
    logic             out_fire;

    assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

    // Field packing; kind 7 falls through to the NOP default in every build.
    always_comb begin
        enc_word = NOP;
        case (in_kind)
            KIND_R:      enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            KIND_I:      enc_word = is_shift ? {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_I}
                                             : {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
            KIND_LOAD:   enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            KIND_STORE:  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            KIND_BRANCH: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                     in_imm[4:1], in_imm[11], OP_BRANCH};
            KIND_JAL:    enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
            KIND_JALR:   enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
            default:     enc_word = NOP;
        endcase
    end

`ifdef ENCODER_CHECK_EN
    logic signed [20:0] imm_s;
    logic               fits12;

    assign imm_s  = $signed(in_imm);
    assign fits12 = (imm_s >= -21'sd2048) && (imm_s <= 21'sd2047);

    always_comb begin
        imm_bad = 1'b0;
        case (in_kind)
            KIND_I:                          imm_bad = is_shift ? ((imm_s < 21'sd0) || (imm_s > 21'sd31)) : !fits12;
            KIND_LOAD, KIND_STORE, KIND_JALR: imm_bad = !fits12;
            KIND_BRANCH:                     imm_bad = (imm_s < -21'sd4096) || (imm_s > 21'sd4094) || in_imm[0];
            KIND_JAL:                        imm_bad = in_imm[0];
            default:                         imm_bad = 1'b0;
        endcase
    end

    assign kind_bad = (in_kind == 3'd7);
`else
    assign imm_bad  = 1'b0;
    assign kind_bad = 1'b0;
`endif

    assign in_ready = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_instr_d = imm_bad ? NOP : enc_word;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
        // Clearing the counter takes priority over the consume increment.
        if (addr_clr)      out_addr_d = ADDR_RST;
        else if (out_fire) out_addr_d = out_addr_q + ADDR_W'(1);
        else               out_addr_d = out_addr_q;
        err_imm_d  = (err_imm_q && !err_clr) || (in_fire && imm_bad);
        err_kind_d = (err_kind_q && !err_clr) || (in_fire && kind_bad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= ADDR_RST;
            err_imm_q   <= 1'b0;
            err_kind_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            err_imm_q   <= err_imm_d;
            err_kind_q  <= err_kind_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign err_imm   = err_imm_q;
    assign err_kind  = err_kind_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed spec vectors plus a randomized stream scored against a field-level model.
module tb_instr_encoder;
`ifdef ENCODER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [20:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic        addr_clr;
    logic        err_clr;
    logic        err_imm;
    logic        err_kind;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_encoder #(.WIDTH(32), .ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .addr_clr(addr_clr), .err_clr(err_clr),
        .err_imm(err_imm), .err_kind(err_kind)
    );

    function automatic longint fld(input longint v, input int hi, input int lo);
        return (v >>> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    // Reference encoder: field placement by arithmetic on integer values.
    function automatic logic [31:0] ref_encode(input int kind, input int f3, input int f7, input int rd,
                                               input int rs1, input int rs2, input int imm,
                                               output bit ibad, output bit kbad);
        longint w;
        longint v;
        bit ok;
        bit shift;
        v = imm;
        ok = 1'b1;
        kbad = 1'b0;
        shift = (kind == 1) && (f3 == 1 || f3 == 5);
        case (kind)
            0: w = (longint'(f7) << 25) | (longint'(rs2) << 20) | (longint'(rs1) << 15) | (longint'(f3) << 12) | (longint'(rd) << 7) | 'h33;
            1: begin
                if (shift) begin
                    ok = (imm >= 0) && (imm <= 31);
                    w = (longint'(f7) << 25) | (fld(v, 4, 0) << 20) | (longint'(rs1) << 15) | (longint'(f3) << 12) | (longint'(rd) << 7) | 'h13;
                end else begin
                    ok = (imm >= -2048) && (imm <= 2047);
                    w = (fld(v, 11, 0) << 20) | (longint'(rs1) << 15) | (longint'(f3) << 12) | (longint'(rd) << 7) | 'h13;
                end
            end
            2: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w = (fld(v, 11, 0) << 20) | (longint'(rs1) << 15) | (longint'(f3) << 12) | (longint'(rd) << 7) | 'h03;
            end
            3: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w = (fld(v, 11, 5) << 25) | (longint'(rs2) << 20) | (longint'(rs1) << 15) | (longint'(f3) << 12) | (fld(v, 4, 0) << 7) | 'h23;
            end
            4: begin
                ok = (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
                w = (fld(v, 12, 12) << 31) | (fld(v, 10, 5) << 25) | (longint'(rs2) << 20) | (longint'(rs1) << 15)
                  | (longint'(f3) << 12) | (fld(v, 4, 1) << 8) | (fld(v, 11, 11) << 7) | 'h63;
            end
            5: begin
                ok = (imm % 2 == 0);
                w = (fld(v, 20, 20) << 31) | (fld(v, 10, 1) << 21) | (fld(v, 11, 11) << 20) | (fld(v, 19, 12) << 12) | (longint'(rd) << 7) | 'h6F;
            end
            6: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w = (fld(v, 11, 0) << 20) | (longint'(rs1) << 15) | (longint'(rd) << 7) | 'h67;
            end
            default: begin
                w = 'h13;
                kbad = 1'b1;
            end
        endcase
        ibad = CHK && !ok;
        kbad = CHK && kbad;
        if (ibad) w = 'h13;
        return w[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_kind = '0; in_funct3 = '0; in_funct7 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        addr_clr = 1'b0; err_clr = 1'b0;
    endtask

    task automatic drive(input int kind, input int f3, input int f7, input int rd,
                         input int rs1, input int rs2, input int imm);
        in_valid = 1'b1; in_kind = 3'(kind); in_funct3 = 3'(f3); in_funct7 = 7'(f7);
        in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 21'(imm);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=00000000", out_instr); end
        total++; if (out_addr !== 8'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", out_addr); end
        total++; if ({err_imm, err_kind} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b want=00", {err_imm, err_kind}); end
        rst_n = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_r_type();
        out_ready = 1'b0;
        drive(0, 0, 0, 3, 1, 2, 0);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rtype_pre_valid got=%b want=0", out_valid); end
        tick();
        idle_inputs();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rtype_valid got=%b want=1", out_valid); end
        total++; if (out_instr !== 32'h002081B3) begin bad++; $display("FAIL rtype_instr got=%h want=002081b3", out_instr); end
        total++; if (out_addr !== 8'd0) begin bad++; $display("FAIL rtype_addr got=%0d want=0", out_addr); end
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rtype_drain got=%b want=0", out_valid); end
        total++; if (out_addr !== 8'd1) begin bad++; $display("FAIL rtype_next_addr got=%0d want=1", out_addr); end
    endtask

    task automatic test_back_to_back();
        addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        total++; if (out_addr !== 8'd0) begin bad++; $display("FAIL b2b_clr got=%0d want=0", out_addr); end
        out_ready = 1'b1;
        drive(1, 0, 0, 5, 0, 0, -1);
        tick();
        drive(3, 2, 0, 0, 1, 2, 8);
        total++; if (out_instr !== 32'hFFF00293 || out_addr !== 8'd0 || out_valid !== 1'b1)
            begin bad++; $display("FAIL b2b_addi got=%h@%0d v=%b want=fff00293@0 v=1", out_instr, out_addr, out_valid); end
        tick();
        idle_inputs();
        total++; if (out_instr !== 32'h0020A423 || out_addr !== 8'd1 || out_valid !== 1'b1)
            begin bad++; $display("FAIL b2b_sw got=%h@%0d v=%b want=0020a423@1 v=1", out_instr, out_addr, out_valid); end
        tick();
        total++; if (out_valid !== 1'b0 || out_addr !== 8'd2) begin bad++; $display("FAIL b2b_end got=v%b@%0d want=v0@2", out_valid, out_addr); end
    endtask

    task automatic test_branch_jal();
        out_ready = 1'b1;
        drive(4, 0, 0, 0, 1, 2, -4);
        tick();
        drive(5, 0, 0, 1, 0, 0, 2048);
        total++; if (out_instr !== 32'hFE208EE3) begin bad++; $display("FAIL beq_instr got=%h want=fe208ee3", out_instr); end
        tick();
        idle_inputs();
        total++; if (out_instr !== 32'h001000EF) begin bad++; $display("FAIL jal_instr got=%h want=001000ef", out_instr); end
        tick();
    endtask

    task automatic test_errors();
        logic [31:0] exp;
        out_ready = 1'b1;
        drive(1, 0, 0, 5, 0, 0, 2048);
        tick();
        drive(4, 0, 0, 0, 1, 2, 3);
        exp = CHK ? NOP : 32'h80000293;
        total++; if (out_instr !== exp) begin bad++; $display("FAIL err_addi_instr got=%h want=%h", out_instr, exp); end
        total++; if (err_imm !== CHK) begin bad++; $display("FAIL err_addi_flag got=%b want=%b", err_imm, CHK); end
        tick();
        idle_inputs();
        exp = CHK ? NOP : 32'h00208163;
        total++; if (out_instr !== exp) begin bad++; $display("FAIL err_beq_instr got=%h want=%h", out_instr, exp); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (err_imm !== 1'b0) begin bad++; $display("FAIL err_clr got=%b want=0", err_imm); end
        err_clr = 1'b1;
        drive(6, 0, 0, 1, 2, 0, 4096);
        tick();
        idle_inputs();
        exp = CHK ? NOP : 32'h000100E7;
        total++; if (out_instr !== exp) begin bad++; $display("FAIL err_jalr_instr got=%h want=%h", out_instr, exp); end
        total++; if (err_imm !== CHK) begin bad++; $display("FAIL err_set_wins got=%b want=%b", err_imm, CHK); end
        drive(7, 3, 9, 4, 5, 6, 7);
        tick();
        idle_inputs();
        total++; if (out_instr !== NOP) begin bad++; $display("FAIL kind7_instr got=%h want=00000013", out_instr); end
        total++; if (err_kind !== CHK) begin bad++; $display("FAIL kind7_flag got=%b want=%b", err_kind, CHK); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if ({err_imm, err_kind} !== 2'b00) begin bad++; $display("FAIL err_clr_both got=%b want=00", {err_imm, err_kind}); end
    endtask

    task automatic test_stall();
        logic [31:0] a, b;
        bit ib, kb;
        a = ref_encode(0, 0, 32, 7, 3, 4, 0, ib, kb);
        b = ref_encode(1, 0, 0, 1, 1, 0, 1, ib, kb);
        out_ready = 1'b0;
        addr_clr = 1'b1;
        drive(0, 0, 32, 7, 3, 4, 0);
        tick();
        addr_clr = 1'b0;
        drive(1, 0, 0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%b want=0", i, in_ready); end
            total++; if (out_valid !== 1'b1 || out_instr !== a || out_addr !== 8'd0)
                begin bad++; $display("FAIL stall_hold[%0d] got=%h@%0d want=%h@0", i, out_instr, out_addr, a); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        idle_inputs();
        total++; if (out_instr !== b || out_addr !== 8'd1) begin bad++; $display("FAIL stall_release got=%h@%0d want=%h@1", out_instr, out_addr, b); end
        tick();
    endtask

    task automatic test_wrap();
        addr_clr = 1'b1;
        out_ready = 1'b1;
        tick();
        addr_clr = 1'b0;
        for (int i = 0; i < 257; i++) begin
            drive(1, 0, 0, i % 32, 0, 0, i % 2048);
            tick();
            total++; if (out_valid !== 1'b1 || out_addr !== 8'(i))
                begin bad++; $display("FAIL wrap_addr[%0d] got=%0d v=%b want=%0d", i, out_addr, out_valid, i % 256); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_addr_clr();
        logic [31:0] d, e;
        bit ib, kb;
        d = ref_encode(2, 2, 0, 9, 10, 0, -100, ib, kb);
        e = ref_encode(3, 1, 0, 0, 11, 12, -7, ib, kb);
        out_ready = 1'b0;
        drive(0, 7, 1, 2, 3, 4, 0);
        tick();
        total++; if (out_addr !== 8'd1) begin bad++; $display("FAIL clr_pre_addr got=%0d want=1", out_addr); end
        out_ready = 1'b1;
        addr_clr = 1'b1;
        drive(2, 2, 0, 9, 10, 0, -100);
        tick();
        addr_clr = 1'b0;
        drive(3, 1, 0, 0, 11, 12, -7);
        total++; if (out_valid !== 1'b1 || out_instr !== d || out_addr !== 8'd0)
            begin bad++; $display("FAIL clr_handshake got=%h@%0d want=%h@0", out_instr, out_addr, d); end
        tick();
        idle_inputs();
        total++; if (out_instr !== e || out_addr !== 8'd1) begin bad++; $display("FAIL clr_next got=%h@%0d want=%h@1", out_instr, out_addr, e); end
        out_ready = 1'b0;
        addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        total++; if (out_valid !== 1'b1 || out_instr !== e || out_addr !== 8'd0)
            begin bad++; $display("FAIL clr_keep_word got=%h@%0d v=%b want=%h@0 v=1", out_instr, out_addr, out_valid, e); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        addr_clr = 1'b1;
        out_ready = 1'b1;
        tick();
        addr_clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) drive(7, 0, 0, 0, 0, 0, 0);
            else        drive(0, 0, 0, i, i, i, 0);
            tick();
        end
        idle_inputs();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b1 || out_addr !== 8'd5 || err_kind !== CHK)
            begin bad++; $display("FAIL arst_pre got=v%b@%0d ek=%b want=v1@5 ek=%b", out_valid, out_addr, err_kind, CHK); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_addr !== 8'd0 || out_instr !== 32'h0 || err_kind !== 1'b0)
            begin bad++; $display("FAIL arst_now got=v%b@%0d %h ek=%b want=v0@0 00000000 ek=0", out_valid, out_addr, out_instr, err_kind); end
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] w, prev_i;
        logic [7:0]  prev_a;
        bit ib, kb, m_ei, m_ek, stalled, exp_ready;
        int cnt, kind, f3, f7, rd, rs1, rs2, imm;
        cnt = 0; m_ei = 0; m_ek = 0; stalled = 0;
        for (int c = 0; c < 600; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                kind = $urandom_range(0, 7); f3 = $urandom_range(0, 7); f7 = $urandom_range(0, 127);
                rd = $urandom_range(0, 31); rs1 = $urandom_range(0, 31); rs2 = $urandom_range(0, 31);
                case ($urandom_range(0, 3))
                    0: imm = $urandom_range(0, 31);
                    1: imm = int'($urandom_range(0, 8191)) - 4096;
                    2: imm = int'($urandom_range(0, 4095)) - 2048;
                    default: imm = int'($urandom) >>> 11;
                endcase
                drive(kind, f3, f7, rd, rs1, rs2, imm);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            exp_ready = (q.size() == 0) || out_ready;
            total++; if (in_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", c, in_ready, exp_ready); end
            total++; if (out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid[%0d] got=%b want=%b", c, out_valid, q.size() != 0); end
            if (stalled) begin
                total++; if (out_instr !== prev_i || out_addr !== prev_a)
                    begin bad++; $display("FAIL rnd_hold[%0d] got=%h@%0d want=%h@%0d", c, out_instr, out_addr, prev_i, prev_a); end
            end
            if (q.size() != 0 && out_ready) begin
                total++; if (out_instr !== q[0] || out_addr !== 8'(cnt))
                    begin bad++; $display("FAIL rnd_word[%0d] got=%h@%0d want=%h@%0d", c, out_instr, out_addr, q[0], cnt % 256); end
                void'(q.pop_front());
                cnt++;
            end
            if (in_valid && exp_ready) begin
                w = ref_encode(kind, f3, f7, rd, rs1, rs2, imm, ib, kb);
                q.push_back(w);
                m_ei = m_ei | ib;
                m_ek = m_ek | kb;
            end
            stalled = out_valid && !out_ready;
            prev_i = out_instr;
            prev_a = out_addr;
            tick();
            total++; if (err_imm !== m_ei || err_kind !== m_ek)
                begin bad++; $display("FAIL rnd_err[%0d] got=%b%b want=%b%b", c, err_imm, err_kind, m_ei, m_ek); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        out_ready = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_r_type();
        test_back_to_back();
        test_branch_jal();
        test_errors();
        test_stall();
        test_wrap();
        test_addr_clr();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
